// File: rtl/mem_responder.sv
// Word-organised little-endian RAM serving the core's read/write handshakes.
// Define MEM_RESP_CHECK_EN to reject misaligned, invalid-width and out-of-range accesses.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 0,
  localparam int unsigned DATA_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [2:0]            i_wr_width,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic                  o_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    StIdle, StRdWait, StRdResp, StWrWait, StWrDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            width_q, width_d;
  logic                  is_wr_q, is_wr_d;
  logic                  rd_valid_q, wr_ready_q;
  logic [DATA_WIDTH-1:0] data_q, rdata_q;
  logic                  rd_fetch, wr_commit, req_bad;
  logic [IdxW-1:0]       idx;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlane;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  assign idx = addr_q[IdxW+1:2];

  // Lane enables; data is replicated so every enabled lane sees the right byte.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (width_q)
      3'b000: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

`ifdef MEM_RESP_CHECK_EN
  logic range_bad, width_bad, err_q;

  assign range_bad = addr_q >= 32'(4 * DEPTH_WORDS);

  always_comb begin
    width_bad = 1'b1;
    case (width_q)
      3'b000:  width_bad = 1'b0;
      3'b001:  width_bad = addr_q[0];
      3'b010:  width_bad = |addr_q[1:0];
      default: width_bad = 1'b1;
    endcase
  end

  // Reads carry no width, so only the range check applies to them.
  assign req_bad = range_bad | (is_wr_q & width_bad);

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= (state_q == StErr);
  end

  assign o_err = err_q;
`else
  logic unused_addr;

  assign req_bad     = 1'b0;
  assign unused_addr = ^addr_q[31:IdxW+2];
  assign o_err       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    is_wr_d  = is_wr_q;
    rd_fetch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_wr_valid) begin
          addr_d  = i_addr;
          wdata_d = i_data;
          width_d = i_wr_width;
          is_wr_d = 1'b1;
          cnt_d   = 4'(WRITE_LATENCY);
          state_d = StWrWait;
        end else if (i_rd_ready) begin
          addr_d  = i_addr;
          is_wr_d = 1'b0;
          cnt_d   = 4'(READ_LATENCY);
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (!i_rd_ready) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (req_bad) begin
          state_d = StErr;
        end else if (cnt_q == '0) begin
          rd_fetch = 1'b1;
          state_d  = StRdResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrWait: begin
        if (!i_wr_valid) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (req_bad) begin
          state_d = StErr;
        end else if (cnt_q == '0) begin
          state_d = StWrDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdResp, StWrDone, StErr: state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
      is_wr_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      width_q    <= width_d;
      is_wr_q    <= is_wr_d;
      rd_valid_q <= (state_q == StRdResp) | ((state_q == StErr) & ~is_wr_q);
      wr_ready_q <= (state_q == StWrDone) | ((state_q == StErr) & is_wr_q);
      if (state_q == StRdResp)  data_q <= rdata_q;
      else if (state_q == StErr) data_q <= '0;
    end
  end

  // Commit lands on the same edge as the ready pulse; reset on that edge cancels it.
  assign wr_commit = (state_q == StWrDone) & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (wr_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
    if (rd_fetch) rdata_q <= mem[idx];
  end

  assign o_rd_valid = rd_valid_q;
  assign o_wr_ready = wr_ready_q;
  assign o_data     = data_q;

endmodule
